// File: rtl/serial_parallel_pkg.sv
// Shared types and constants for the serial link deserializer.
// COMMA_K285 matches the idle symbol emitted by the transmit serializer.
package serial_parallel_pkg;

  localparam int unsigned WORD_W = 8;

  localparam logic [WORD_W-1:0] COMMA_K285 = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH,
    LOCK,
    ACTIVE
  } state_e;

endpackage

// File: rtl/serial_comma_shift.sv
// MSB-first shift register with a comma detector on the next-state window,
// so a comma is seen on the same edge that samples its last bit.
module serial_comma_shift
  import serial_parallel_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA = COMMA_K285
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in_serial,
  output logic [WORD_W-1:0] nsr,
  output logic              comma_hit
);

  logic [WORD_W-1:0] sr_q;

  assign nsr       = {sr_q[WORD_W-2:0], data_in_serial};
  assign comma_hit = (nsr == COMMA);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= nsr;
    end
  end

endmodule

// File: rtl/serial_parallel.sv
// Receive deserializer: hunts for comma alignment, locks after LOCK_COUNT
// aligned commas, then emits data words with a valid flag (commas are idle).
module serial_parallel
  import serial_parallel_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA      = COMMA_K285,
  parameter int unsigned       LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in_serial,
  output logic [WORD_W-1:0] data_out_8b,
  output logic              valid_out,
  output logic              word_tick,
  output logic              active
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        comma_cnt_q, comma_cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              tick_q, tick_d;

  logic [WORD_W-1:0] nsr;
  logic              comma_hit;
  logic              boundary;

  serial_comma_shift #(
    .COMMA(COMMA)
  ) u_shift (
    .clk           (clk),
    .reset         (reset),
    .data_in_serial(data_in_serial),
    .nsr           (nsr),
    .comma_hit     (comma_hit)
  );

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    tick_d      = 1'b0;

    unique case (state_q)
      SEARCH: begin
        // Compared every bit so any alignment offset is found.
        bit_cnt_d = '0;
        if (comma_hit) begin
          comma_cnt_d = 4'd1;
          state_d     = (LockCnt == 4'd1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        if (boundary) begin
          if (!comma_hit) begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end else begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == LockCnt) begin
              state_d = ACTIVE;
            end
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          tick_d  = 1'b1;
          valid_d = !comma_hit;
          if (!comma_hit) begin
            data_d = nsr;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
    end
  end

  assign data_out_8b = data_q;
  assign valid_out   = valid_q;
  assign word_tick   = tick_q;
  assign active      = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_parallel.sv
// Directed bench for serial_parallel: lock, data, idle, false lock, reset
// mid-word, and the single-comma lock variant.
module tb_serial_parallel;

  logic       clk;
  logic       reset;
  logic       din;
  logic [7:0] data4, data1;
  logic       valid4, valid1, tick4, tick1, active4, active1;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_parallel #(
    .LOCK_COUNT(4)
  ) dut4 (
    .clk           (clk),
    .reset         (reset),
    .data_in_serial(din),
    .data_out_8b   (data4),
    .valid_out     (valid4),
    .word_tick     (tick4),
    .active        (active4)
  );

  serial_parallel #(
    .LOCK_COUNT(1)
  ) dut1 (
    .clk           (clk),
    .reset         (reset),
    .data_in_serial(din),
    .data_out_8b   (data1),
    .valid_out     (valid1),
    .word_tick     (tick1),
    .active        (active1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends three commas plus seven bits of the fourth, checks no lock yet,
  // then the last bit and checks lock on that edge.
  task automatic lock4(input string tag);
    logic [7:0] c;
    c = 8'hBC;
    for (int k = 0; k < 3; k++) send_byte(c);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    check({tag, "_prelock"}, 32'(active4), 32'd0);
    send_bit(c[0]);
    check({tag, "_lock"}, 32'(active4), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b0;
    din   = 1'b0;

    // Reset state
    do_reset();
    check("rst_data", 32'(data4), 32'h00);
    check("rst_valid", 32'(valid4), 32'd0);
    check("rst_tick", 32'(tick4), 32'd0);
    check("rst_active", 32'(active4), 32'd0);

    // 1: lock at edge 32, data at 40 and 48
    lock4("t1");
    check("t1_tick_at_lock", 32'(tick4), 32'd0);
    check("t1_valid_at_lock", 32'(valid4), 32'd0);
    send_byte(8'h5A);
    check("t1_data_5a", 32'(data4), 32'h5A);
    check("t1_valid_5a", 32'(valid4), 32'd1);
    check("t1_tick_40", 32'(tick4), 32'd1);
    b = 8'hC3;
    send_bit(b[7]);
    check("t1_tick_41", 32'(tick4), 32'd0);
    check("t1_valid_held", 32'(valid4), 32'd1);
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    check("t1_data_c3", 32'(data4), 32'hC3);
    check("t1_tick_48", 32'(tick4), 32'd1);

    // 3: data, idle comma, data
    send_byte(8'h11);
    check("t3_data_11", 32'(data4), 32'h11);
    check("t3_valid_11", 32'(valid4), 32'd1);
    send_byte(8'hBC);
    check("t3_idle_valid", 32'(valid4), 32'd0);
    check("t3_idle_hold", 32'(data4), 32'h11);
    check("t3_idle_tick", 32'(tick4), 32'd1);
    send_byte(8'h22);
    check("t3_data_22", 32'(data4), 32'h22);
    check("t3_valid_22", 32'(valid4), 32'd1);

    // 5: reset mid-word clears everything, relock needs four fresh commas
    b = 8'h44;
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    do_reset();
    check("t5_data", 32'(data4), 32'h00);
    check("t5_valid", 32'(valid4), 32'd0);
    check("t5_tick", 32'(tick4), 32'd0);
    check("t5_active", 32'(active4), 32'd0);
    lock4("t5");

    // 2: three garbage bits shift everything by +3 edges
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock4("t2");
    send_byte(8'h5A);
    check("t2_data_5a", 32'(data4), 32'h5A);
    check("t2_valid_5a", 32'(valid4), 32'd1);

    // 4: a non-comma during LOCK drops back to SEARCH
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    check("t4_after_00", 32'(active4), 32'd0);
    lock4("t4");
    send_byte(8'h77);
    check("t4_data_77", 32'(data4), 32'h77);
    check("t4_valid_77", 32'(valid4), 32'd1);

    // 6: LOCK_COUNT=1 locks on the first comma
    do_reset();
    b = 8'hBC;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    check("t6_prelock", 32'(active1), 32'd0);
    send_bit(b[0]);
    check("t6_lock", 32'(active1), 32'd1);
    check("t6_tick_8", 32'(tick1), 32'd0);
    send_byte(8'hFF);
    check("t6_data_ff", 32'(data1), 32'hFF);
    check("t6_valid_ff", 32'(valid1), 32'd1);
    check("t6_tick_16", 32'(tick1), 32'd1);
    b = 8'h80;
    send_bit(b[7]);
    check("t6_tick_17", 32'(tick1), 32'd0);
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    check("t6_data_80", 32'(data1), 32'h80);
    check("t6_tick_24", 32'(tick1), 32'd1);
    check("t6_dut4_unlocked", 32'(active4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
Receive-side deserializer. It consumes the 1-bit MSB-first serial stream from the transmit serializer and rebuilds 8-bit words. It finds word alignment by hunting for the idle comma 0xBC, and declares lock after LOCK_COUNT consecutive aligned commas. Once locked, it presents data words with a valid flag, treating idle commas as no-data.

Parameters:
COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when it has no valid data.
LOCK_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
clk  input  1  bit clock; all logic on rising edge.
reset  input  1  reset, synchronous, active-high.
data_in_serial  input  1  serial bit; MSB of each word first.
data_out_8b  output  8  last received non-comma data word.
valid_out  output  1  high for one word period when data_out_8b was loaded with a new data word.
word_tick  output  1  one-clk pulse on every word boundary while ACTIVE.
active  output  1  high while locked (state ACTIVE).

Behaviour:
- Reset (sampled on a clk edge): state=SEARCH; shift register sr=0; bit_cnt=0; comma_cnt=0; data_out_8b=0; valid_out=0; word_tick=0; active=0.
- Reset mid-operation: the same values are applied on that edge, and the block relocks from scratch.
- Every edge, nsr = {sr[6:0], data_in_serial}, then sr <= nsr.
- SEARCH:
  - If nsr==COMMA, set bit_cnt<=0 and comma_cnt<=1.
  - Go to ACTIVE if LOCK_COUNT==1, otherwise go to LOCK.
  - Otherwise stay in SEARCH. The comparison is made every bit, so any bit offset is found.
- LOCK: bit_cnt increments mod 8. The word boundary is the edge with bit_cnt==7, and word = nsr.
  - word==COMMA, comma_cnt+1==LOCK_COUNT: go to ACTIVE, set active<=1 on this same edge.
  - word==COMMA otherwise: comma_cnt++.
  - word!=COMMA: go to SEARCH, comma_cnt<=0. Hunting resumes from the next bit; no re-check of the current nsr.
- ACTIVE: bit_cnt increments mod 8. At each word boundary (bit_cnt==7):
  - word_tick<=1 for one clk.
  - word!=COMMA: data_out_8b<=word, valid_out<=1.
  - word==COMMA: valid_out<=0, data_out_8b holds.
  - valid_out is held for the whole 8-clk word period and updates only at boundaries.
- Lock is lost only through reset. There is no slip detection.
- Latency: data_out_8b and valid_out update on the same edge that samples the word's LSB, i.e. zero extra cycles after the 8th bit.
- Widths: bit_cnt 3 bits, wraps 7->0. comma_cnt 4 bits, never exceeds LOCK_COUNT.
- Outside ACTIVE: valid_out=0 and word_tick=0.

Decomposition:
- Shared package holds:
  - COMMA_K285 = 8'hBC constant, shared with the serializer.
  - State enum {SEARCH, LOCK, ACTIVE}.
  - WORD_W = 8.
- One natural sub-module, serial_comma_shift: the shift register plus COMMA comparator, producing nsr and comma_hit. The FSM, counters and output registers stay in serial_parallel.

Test Plan:
1. Reset, then bits of BC,BC,BC,BC,0x5A,0xC3 from cycle 1 -> active=1 at edge 32; data_out_8b=0x5A, valid_out=1 at edge 40; 0xC3 at edge 48; word_tick pulses at 40 and 48.
2. Same stream preceded by 3 garbage bits 1,0,1 -> identical outputs shifted by +3 edges (active at 35, 0x5A at 43).
3. Locked; send 0x11, BC, 0x22 -> valid 1 (0x11), then valid 0 with data_out_8b=0x11 held, then valid 1 (0x22).
4. Reset, then BC,BC,0x00,BC,BC,BC,BC,0x77 -> active stays 0 through the 0x00 (back to SEARCH); active=1 at edge 56; 0x77 at edge 64.
5. Locked stream, reset asserted mid-word for 1 clk -> next edge: all outputs 0, active=0; relock requires 4 fresh commas.
6. LOCK_COUNT=1, reset, BC then 0xFF,0x80 -> active=1 at edge 8; 0xFF at 16; 0x80 at 24; word_tick every 8 edges.
